// File: rtl/uart_rx_corr5.sv
// UART receiver (start, DATA_WIDTH data bits LSB-first, stop) with an AXI-Stream output and a one-entry holding buffer.
// Define UART_RX_MAJORITY_EN to make every bit decision a 2-of-3 vote around the bit centre.
module uart_rx_corr5 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic                  rxd_reg;
    logic [1:0]            hist;
    logic                  sample;
    logic [18:0]           timer;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic [15:0]           ps;
    logic [18:0]           bit_reload;
    logic [18:0]           half_reload;
    logic                  tick;
    logic                  handshake;
    logic                  complete;

    assign ps          = (prescale == 16'd0) ? 16'd1 : prescale;
    assign bit_reload  = {ps, 3'b000} - 19'd1;
    assign half_reload = {1'b0, ps, 2'b00} - 19'd1;
    assign tick        = (timer == '0);
    assign handshake   = m_axis_tvalid & m_axis_tready;
    assign complete    = (state == STOP) && tick && sample;

    // The decision cycle is one cycle after the nominal centre so that the
    // centre+1 sample is available; both builds share that timing.
`ifdef UART_RX_MAJORITY_EN
    assign sample = (rxd_reg & hist[0]) | (rxd_reg & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = hist[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rxd_reg       <= 1'b1;
            hist          <= '1;
            timer         <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rxd_reg     <= rxd;
            hist        <= {hist[0], rxd_reg};
            frame_error <= 1'b0;
            if (!tick) timer <= timer - 19'd1;

            case (state)
                IDLE: begin
                    if (!rxd_reg) begin
                        state <= START;
                        busy  <= 1'b1;
                        timer <= half_reload;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!sample) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            timer   <= bit_reload;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {sample, shift_reg[DATA_WIDTH-1:1]};
                        timer     <= bit_reload;
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) state <= STOP;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!sample) frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion is evaluated after the handshake so that a new byte
            // landing on a busy slot overrides the handshake's flag clear.
            if (handshake) begin
                overrun_error <= 1'b0;
                if (hold_full) begin
                    m_axis_tdata <= hold_data;
                    hold_full    <= 1'b0;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end

            if (complete) begin
                if (!m_axis_tvalid || (handshake && !hold_full)) begin
                    m_axis_tdata  <= shift_reg;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    hold_data     <= shift_reg;
                    hold_full     <= 1'b1;
                    overrun_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_corr5.sv
// Directed self-checking bench for uart_rx_corr5 at prescale=6 (48 clk per bit).
module tb_uart_rx_corr5;

    localparam int BIT = 48;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       rxd;
    logic       busy;
    logic       overrun_error;
    logic       frame_error;
    logic [15:0] prescale;

    int tests_run = 0;
    int tests_failed = 0;
    int fe_cnt = 0;
    logic [7:0] rx_q[$];

    uart_rx_corr5 #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    // Record every delivered byte and every frame_error high cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
            if (frame_error) fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
        drive_bit(stop_val, BIT);
        drive_bit(1'b1, 20);
    endtask

    task automatic sample_point;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        m_axis_tready = 1'b0;
        prescale = 16'd6;
        cycles(3);
        sample_point();
        check("reset_tvalid",  m_axis_tvalid, 0);
        check("reset_tdata",   m_axis_tdata, 0);
        check("reset_busy",    busy, 0);
        check("reset_overrun", overrun_error, 0);
        check("reset_ferr",    frame_error, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(5);

        // Single byte with consumer always ready.
        m_axis_tready = 1'b1;
        rx_q.delete();
        fe_cnt = 0;
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT / 2);
        sample_point();
        check("t1_busy_mid", busy, 1);
        @(posedge clk); #1;
        drive_bit(1'b1, BIT / 2 - 1);
        for (int i = 1; i < 8; i++) drive_bit(((8'hA5 >> i) & 8'h1) != 0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b1, 20);
        sample_point();
        check("t1_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t1_data", rx_q[0], 8'hA5);
        check("t1_tvalid_after", m_axis_tvalid, 0);
        check("t1_overrun", overrun_error, 0);
        check("t1_ferr_cnt", fe_cnt, 0);
        check("t1_busy_after", busy, 0);

        // Two bytes with consumer stalled: second goes to holding buffer.
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        rx_q.delete();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
        sample_point();
        check("t2_tvalid", m_axis_tvalid, 1);
        check("t2_tdata", m_axis_tdata, 8'hA5);
        check("t2_overrun", overrun_error, 1);
        cycles(30);
        sample_point();
        check("t2_overrun_sticky", overrun_error, 1);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        sample_point();
        check("t2_hs_tdata", m_axis_tdata, 8'h5A);
        check("t2_hs_tvalid", m_axis_tvalid, 1);
        check("t2_hs_overrun", overrun_error, 0);
        @(posedge clk); #1;
        sample_point();
        check("t2_drain_tvalid", m_axis_tvalid, 0);
        check("t2_count", rx_q.size(), 2);
        if (rx_q.size() > 1) check("t2_q1", rx_q[1], 8'h5A);

        // Three bytes stalled: holding buffer keeps only the newest.
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        rx_q.delete();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        sample_point();
        check("t3_tdata", m_axis_tdata, 8'h11);
        check("t3_overrun", overrun_error, 1);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        cycles(4);
        sample_point();
        check("t3_count", rx_q.size(), 2);
        if (rx_q.size() > 1) check("t3_second", rx_q[1], 8'h33);
        check("t3_overrun_clr", overrun_error, 0);
        check("t3_tvalid_end", m_axis_tvalid, 0);

        // Bad stop bit.
        rx_q.delete();
        fe_cnt = 0;
        send_frame(8'h96, 1'b0);
        sample_point();
        check("t4_ferr_cnt", fe_cnt, 1);
        check("t4_count", rx_q.size(), 0);
        check("t4_tvalid", m_axis_tvalid, 0);
        check("t4_busy", busy, 0);

        // One-cycle glitch.
        @(posedge clk); #1;
        fe_cnt = 0;
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 3);
        sample_point();
        check("t5_busy_start", busy, 1);
        cycles(BIT / 2 + 4);
        sample_point();
        check("t5_busy_end", busy, 0);
        check("t5_count", rx_q.size(), 0);
        check("t5_ferr", fe_cnt, 0);
        check("t5_overrun", overrun_error, 0);

        // Reset mid-frame, then a clean frame.
        @(posedge clk); #1;
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b0, BIT / 2);
        rst = 1'b1;
        rxd = 1'b1;
        cycles(2);
        sample_point();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tvalid", m_axis_tvalid, 0);
        check("t6_rst_tdata", m_axis_tdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(5);
        rx_q.delete();
        send_frame(8'h3C, 1'b1);
        sample_point();
        check("t6_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t6_data", rx_q[0], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
